// File: rtl/shift_add_mult_hs.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult_hs
//  Purpose  : Sequential shift-add multiplier, BITS_PER_CYCLE multiplier bits
//             retired per cycle, valid/ready handshakes on both sides,
//             per-operation signed/unsigned mode.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mult_hs #(
   parameter int WIDTH          = 8,   // operand width, >= 2
   parameter int BITS_PER_CYCLE = 1    // 1, 2 or 4; must divide WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   is_signed,
   input  logic [WIDTH-1:0]       A,
   input  logic [WIDTH-1:0]       B,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*WIDTH-1:0]     product,
   output logic                   busy
);

   localparam int N      = WIDTH / BITS_PER_CYCLE;
   localparam int PW     = 2 * WIDTH;
   localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      a_sh_q, a_sh_d;       // |A| pre-shifted to the current chunk weight
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;     // |B|, consumed LSB first
   logic               neg_q, neg_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]      product_q, product_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;

   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_neg;
   logic [PW-1:0]      w_partial;
   logic [PW-1:0]      w_acc_sum;

   // Operand magnitudes; -2^(W-1) negates to 2^(W-1), which fits unsigned in W bits
   always_comb begin
      w_a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
      w_b_mag = (is_signed && B[WIDTH-1]) ? -B : B;
      w_neg   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
   end

   // Partial product of the shifted multiplicand with the current multiplier chunk
   always_comb begin
      w_partial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (b_mag_q[i]) begin
            w_partial = w_partial + (a_sh_q << i);
         end
      end
      w_acc_sum = acc_q + w_partial;
   end

   // Next-state and datapath update for the IDLE -> CALC -> DONE sequence
   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_mag_d     = b_mag_q;
      neg_d       = neg_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      product_d   = product_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d     = {{WIDTH{1'b0}}, w_a_mag};
               b_mag_d    = w_b_mag;
               neg_d      = w_neg;
               acc_d      = '0;
               cnt_d      = '0;
               state_d    = S_CALC;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_CALC: begin
            acc_d   = w_acc_sum;
            a_sh_d  = a_sh_q << BITS_PER_CYCLE;
            b_mag_d = b_mag_q >> BITS_PER_CYCLE;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               // Negating a zero magnitude yields zero, so no special case is needed
               product_d   = neg_q ? -w_acc_sum : w_acc_sum;
               state_d     = S_DONE;
               out_valid_d = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_sh_q      <= '0;
         b_mag_q     <= '0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_mag_q     <= b_mag_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire
